conv_window_ctrl: RTL
=====================

Name: conv_window_ctrl

Overview:
- Sequencer for the 3x3 sliding-window generator (two line buffers plus tap registers) that feeds the convolution engine.
- Accepts a raster pixel stream under valid/ready and drives the window generator's shift enable.
- Tracks row and column; flags only windows lying fully inside the image, never windows wrapping across a row edge.
- Propagates downstream backpressure and reports frame completion.

Parameters:
- IMG_WIDTH, 34, pixels per row; must be >= 3.
- IMG_HEIGHT, 34, rows per frame; must be >= 3.
- CNT_W, 6, width of the row/column counters and coordinate outputs; must satisfy 2^CNT_W >= max(IMG_WIDTH, IMG_HEIGHT).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-high: asserted when resetn=1, sampled on rising clk.
- frame_start  in  1  one-cycle pulse; arms the block for a new frame.
- pix_valid  in  1  upstream pixel present.
- pix_ready  out  1  block accepts the pixel this cycle.
- lb_shift_en  out  1  shift enable to the window generator's data_valid_in.
- win_valid  out  1  window taps w1..w9 form a valid in-image window this cycle.
- win_ready  in  1  downstream consumes the window this cycle.
- win_row  out  CNT_W  top-left row of the current window.
- win_col  out  CNT_W  top-left column of the current window.
- busy  out  1  high in FILL, RUN or DONE.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
- States: IDLE, FILL, RUN, DONE.
  - IDLE -> FILL on frame_start.
  - FILL -> RUN on accepting pixel (row 2, col 1), so the next pixel yields the first window.
  - FILL/RUN -> DONE on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - DONE -> IDLE unconditionally next cycle; frame_done=1 during the DONE cycle.
- Reset values: state=IDLE; row=col=0; pix_ready=0, lb_shift_en=0, win_valid=0, busy=0, frame_done=0; win_row=win_col=0.
- accept = pix_valid & pix_ready. lb_shift_en = accept, combinational, same cycle.
- win_pos = (row >= 2) & (col >= 2) for the pixel currently presented.
- pix_ready = (state is FILL or RUN) & (win_ready | ~win_pos). The combinational win_ready -> pix_ready path is intended.
- win_valid = accept & win_pos. Window tap 9 is the live input, so latency is zero: the window is valid in the same cycle its last pixel is presented.
- win_row = row-2 and win_col = col-2 while win_valid=1. Hold their last value otherwise.
- Counters advance only on accept.
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - row wraps to 0 at end of frame.
- Columns 0 and 1 of each row never assert win_valid; these positions suppress windows that straddle two rows.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2); 1024 at defaults.
- frame_start outside IDLE is ignored.
- frame_start coincident with resetn=1: reset wins.
- pix_valid while IDLE or DONE: pix_ready=0, nothing shifts.
- Reset mid-frame returns to IDLE with counters cleared. Stale line-buffer contents cannot produce win_valid because FILL restarts from row 0.
- Stall with pix_valid=1, win_pos=1, win_ready=0: no accept, no shift, counters frozen. Upstream must hold the pixel.

Optional Feature:
- Macro CONV_WIN_STRIDE2_EN.
- Defined: stride-2 window decimation.
  - win_valid additionally requires (row-2) and (col-2) both even.
  - Suppressed positions do not wait on win_ready: pix_ready treats them as ~win_pos.
  - Windows per frame: ceil((IMG_WIDTH-2)/2)*ceil((IMG_HEIGHT-2)/2).
  - win_row and win_col still report full-resolution coordinates.
- Undefined: stride 1 as specified above.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, frame_start, 20 back-to-back pixels, win_ready=1 -> exactly 6 win_valid pulses at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). frame_done one cycle after the 20th accept. lb_shift_en high for exactly 20 cycles.
- Same frame, win_ready=0 when pixel (2,2) is presented -> pix_ready=0, lb_shift_en=0, counters frozen for 3 cycles. Resuming win_ready=1 emits window (0,0) once; no duplicate, no loss.
- pix_valid=1 with no frame_start -> pix_ready stays 0 and zero shifts. frame_start while in RUN -> ignored; window count still 6.
- resetn=1 after 12 accepts, then a new full frame -> state IDLE and counters 0 after reset. The new frame yields 6 windows; the first appears only after 13 accepts.
- Defaults 34x34 -> 1024 windows. win_col never equals 32 or 33. The last window is at (31,31).
- CONV_WIN_STRIDE2_EN, IMG_WIDTH=6, IMG_HEIGHT=6 -> 4 windows at (0,0),(0,2),(2,0),(2,2). win_ready=0 at odd positions never stalls pix_ready.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// Sequencer for the 3x3 sliding-window generator: raster pixel handshake, row/col tracking,
// in-image window flagging and frame completion. Optional macro CONV_WIN_STRIDE2_EN enables stride-2 decimation.
module conv_window_ctrl #(
  parameter int IMG_WIDTH  = 34,
  parameter int IMG_HEIGHT = 34,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frame_start,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             lb_shift_en,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_win_row;
  logic [CNT_W-1:0] r_win_col;

  logic w_active;
  logic w_win_pos;
  logic w_accept;
  logic w_eol;
  logic w_last_pix;
  logic w_run_pix;

  // Handshake: a pixel moves when pix_valid & pix_ready in the same cycle; a window is
  // consumed when win_valid & win_ready. pix_ready depends combinationally on win_ready
  // so a window-producing pixel is only taken when downstream can take the window too.
  always_comb begin
    w_active  = (r_state == S_FILL) || (r_state == S_RUN);
    w_win_pos = (r_row >= TWO) && (r_col >= TWO);
`ifdef CONV_WIN_STRIDE2_EN
    // row-2 and col-2 even is the same as row and col even
    w_win_pos = w_win_pos && !r_row[0] && !r_col[0];
`endif
    pix_ready   = w_active && (win_ready || !w_win_pos);
    w_accept    = pix_valid && pix_ready;
    lb_shift_en = w_accept;
    win_valid   = w_accept && w_win_pos;
    w_eol       = (r_col == LAST_COL);
    w_last_pix  = w_eol && (r_row == LAST_ROW);
    w_run_pix   = (r_row == TWO) && (r_col == ONE);
    win_row     = win_valid ? (r_row - TWO) : r_win_row;
    win_col     = win_valid ? (r_col - TWO) : r_win_col;
    busy        = (r_state != S_IDLE);
    frame_done  = (r_state == S_DONE);
    dbg_state   = r_state;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_win_row <= '0;
      r_win_col <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (frame_start) r_state <= S_FILL;
        S_FILL, S_RUN: begin
          if (w_accept) begin
            if (w_last_pix)
              r_state <= S_DONE;
            else if ((r_state == S_FILL) && w_run_pix)
              r_state <= S_RUN;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_accept) begin
        if (w_eol) begin
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : (r_row + ONE);
        end else begin
          r_col <= r_col + ONE;
        end
      end

      if (win_valid) begin
        r_win_row <= r_row - TWO;
        r_win_col <= r_col - TWO;
      end
    end
  end

endmodule
